// File: rtl/mem_ctrl.sv
// mem_ctrl: CPU-to-RAM access controller with word/byte reads, word writes and read-modify-write byte writes
module mem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic              byte_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_en,
    inout  wire  [WORD_W-1:0] ram_data
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD     = 3'd1;
    localparam logic [2:0] WR     = 3'd2;
    localparam logic [2:0] RMW_RD = 3'd3;
    localparam logic [2:0] RMW_WR = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              byte_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-9:0] hi_q;
    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] wr_word;
    logic              top_word;

    // A word at the top byte address would straddle the end of RAM, so it is rejected
    assign top_word = !byte_op && (addr == {ADDR_W{1'b1}});

    // Next-state routing; requests outside IDLE are dropped, not queued
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !req ? IDLE : top_word ? DONE : (byte_op && we) ? RMW_RD : we ? WR : RD;
            RD:      state_d = DONE;
            WR:      state_d = DONE;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latches, read capture and the preserved high byte for byte writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            byte_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hi_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                byte_q  <= byte_op;
                err_q   <= top_word;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state_q == RD)
                rdata_q <= byte_q ? {{(WORD_W-8){1'b0}}, ram_data[7:0]} : ram_data;
            if (state_q == RMW_RD)
                hi_q <= ram_data[WORD_W-1:8];
        end
    end

    assign wr_word   = (state_q == RMW_WR) ? {hi_q, wdata_q[7:0]} : wdata_q;
    assign ram_wr_en = (state_q == WR) || (state_q == RMW_WR);
    assign ram_data  = ram_wr_en ? wr_word : {WORD_W{1'bz}};
    assign ram_addr  = addr_q;
    assign rdata     = rdata_q;
    assign ack       = (state_q == DONE);
    assign err       = (state_q == DONE) && err_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width; SHALL equal the RAM address width.
REQ-002 Parameter WORD_W, default 16, data word width; SHALL be 16 (two bytes, little-endian).
REQ-003 clk  input  1  single system clock; all state SHALL update on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  CPU access request; sampled only in IDLE.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 byte_op  input  1  1 = byte access (low byte), 0 = word access; sampled with req.
REQ-008 addr  input  ADDR_W  CPU byte address; sampled with req.
REQ-009 wdata  input  WORD_W  write data; sampled with req; byte writes use wdata[7:0].
REQ-010 rdata  output  WORD_W  registered read data; held until the next read completes.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 err  output  1  asserted with ack when the access was rejected.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 ram_addr  output  ADDR_W  address to the RAM.
REQ-015 ram_wr_en  output  1  RAM write enable; RAM writes {addr+1, addr} on the clk edge while high.
REQ-016 ram_data  inout  WORD_W  shared RAM data bus; RAM drives it combinationally while ram_wr_en=0.

Function
REQ-017 FSM states SHALL be IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
REQ-018 IDLE with req=1 SHALL latch we, byte_op, addr and wdata at the clock edge.
- Routing from IDLE: word read -> RD; word write -> WR; byte read -> RD; byte write -> RMW_RD.
REQ-019 A word access with addr = 2**ADDR_W-1 SHALL go directly to DONE with err=1, perform no RAM cycle, and leave rdata unchanged.
- A byte access at the top address is legal.
REQ-020 RD SHALL present ram_addr = latched addr with ram_wr_en=0, and capture ram_data into rdata at the edge leaving RD.
- Word read: rdata = ram_data.
- Byte read: rdata = {8'h00, ram_data[7:0]}.
- Next state: DONE.
REQ-021 WR SHALL assert ram_wr_en=1 and drive ram_data = latched wdata for exactly one cycle; next state DONE.
REQ-022 RMW_RD SHALL read the word at the latched addr and register ram_data[15:8] internally; next state RMW_WR.
REQ-023 RMW_WR SHALL write {captured high byte, wdata[7:0]} with ram_wr_en=1 for one cycle; next state DONE.
- The adjacent byte SHALL be preserved.
REQ-024 DONE SHALL assert ack=1 for exactly one cycle and return to IDLE.
- err=1 in DONE only for accesses rejected per REQ-019.
REQ-025 Outside DONE, ack and err SHALL be 0.
REQ-026 ram_data SHALL be driven only while ram_wr_en=1 and SHALL be high-Z otherwise.
- No cycle may have both sides driving the bus.
REQ-027 ram_wr_en SHALL be 1 only in WR and RMW_WR.
REQ-028 Outside RD, WR, RMW_RD and RMW_WR, ram_addr SHALL hold the last latched address.
REQ-029 Latency, counted from the accepting edge to the first cycle with ack high:
- word read, word write, byte read: 2 cycles;
- byte write: 3 cycles;
- rejected access: 1 cycle.
REQ-030 req while busy=1 SHALL be ignored, not queued.
- A new request is accepted the cycle after ack, at the earliest.
- Max throughput: one word access every 3 cycles.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force:
- state IDLE;
- ram_wr_en=0 and ram_data high-Z;
- ack=0, err=0, busy=0;
- rdata=0, ram_addr=0, internal latches=0.
REQ-032 Reset during WR or RMW_WR SHALL abort the access; whether that RAM word was written is undefined.
- No ack SHALL be issued for the aborted access.
REQ-033 After rst_n rises, the first req SHALL be accepted on the next rising edge.

Verification
REQ-034 Word write, then read back:
- write req addr=8'h10, wdata=16'hBEEF -> ram_wr_en high 1 cycle, RAM[10]=EF, RAM[11]=BE, ack 2 cycles after accept;
- read addr=8'h10 -> rdata=16'hBEEF.
REQ-035 Byte write preserves the neighbour:
- preload RAM[20]=34, RAM[21]=12;
- byte write addr=8'h20, wdata=16'hFF56 -> RAM[20]=56, RAM[21]=12 unchanged, ack 3 cycles after accept;
- byte read addr=8'h20 -> rdata=16'h0056.
REQ-036 Top-address word access:
- word read addr=8'hFF -> ack+err 1 cycle after accept, no RAM cycle, rdata unchanged;
- byte read addr=8'hFF -> err=0.
REQ-037 Busy protection:
- req held high continuously through a write -> second access accepted only the cycle after ack;
- bus never driven by controller while ram_wr_en=0.
REQ-038 Reset mid-write:
- rst_n low during WR -> ram_wr_en=0 and bus high-Z in the same cycle, no ack;
- after release, word read addr=8'h00 completes normally.
